// File: rtl/dma_copy.sv
// dma_copy: single-channel memory-to-memory DMA copy engine.
// The CPU programs SRC/DST/LEN/CTRL through the responder port. The master port
// then copies LEN words (read SRC, write DST) and sets done, with an optional IRQ.
// Optional feature: define DMA_TIMEOUT_EN to abort a beat whose grant takes
// TIMEOUT_CYCLES cycles. The abort sets err and done.
`timescale 1ns/1ps
module dma_copy #(
  parameter int LEN_W          = 16,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        i_CLK,
  input  logic        i_RST,
  input  logic        i_CE,
  input  logic        i_WE,
  input  logic        i_RE,
  input  logic [31:0] i_ADDR,
  input  logic [31:0] i_WDATA,
  input  logic        i_REQ,
  output logic [31:0] o_RDATA,
  output logic        o_GNT,
  output logic        o_M_REQ,
  output logic        o_M_WE,
  output logic        o_M_RE,
  output logic [31:0] o_M_ADDR,
  output logic [31:0] o_M_WDATA,
  input  logic [31:0] i_M_RDATA,
  input  logic        i_M_GNT,
  output logic        o_IRQ
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_RGAP = 3'd2,
    S_WR   = 3'd3,
    S_WGAP = 3'd4
  } state_t;

  localparam logic [31:0] ADDR_SRC  = 32'h0000_0000;
  localparam logic [31:0] ADDR_DST  = 32'h0000_0004;
  localparam logic [31:0] ADDR_LEN  = 32'h0000_0008;
  localparam logic [31:0] ADDR_CTRL = 32'h0000_000C;
  localparam logic [31:0] ADDR_STAT = 32'h0000_0010;

  state_t           r_state, w_nxt_state;
  logic [31:0]      r_src, r_dst, r_sa, r_da, r_buf;
  logic [LEN_W-1:0] r_len, r_cnt;
  logic             r_irq_en, r_done, r_err;
  logic [31:0]      r_rdata;
  logic             r_gnt;
  logic             r_m_req, r_m_we, r_m_re;
  logic [31:0]      r_m_addr, r_m_wdata;

  logic             w_wr, w_rd, w_busy, w_start;
  logic             w_m_req_d, w_m_we_d, w_m_re_d;
  logic [31:0]      w_m_addr_d, w_m_wdata_d, w_rdata_d;
  logic             w_load, w_cap, w_adv, w_set_done, w_set_err, w_tmo_hit;

  assign w_wr    = i_WE & i_REQ & i_CE;
  assign w_rd    = i_RE & i_REQ & i_CE;
  assign w_busy  = (r_state != S_IDLE);
  assign w_start = w_wr & (i_ADDR == ADDR_CTRL) & i_WDATA[0] & ~w_busy;

`ifdef DMA_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] r_tmo;
  assign w_tmo_hit = (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));

  // Grant-wait counter: counts cycles spent in the current RD/WR beat, restarts on every new beat
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      r_tmo <= {TMO_W{1'b0}};
    end else if (((r_state == S_RD) || (r_state == S_WR)) && (w_nxt_state == r_state)) begin
      r_tmo <= r_tmo + TMO_W'(1);
    end else begin
      r_tmo <= {TMO_W{1'b0}};
    end
  end
`else
  assign w_tmo_hit = 1'b0;
`endif

  // Responder read mux, decoded on the register offset
  always_comb begin
    w_rdata_d = 32'd0;
    case (i_ADDR)
      ADDR_SRC:  w_rdata_d = r_src;
      ADDR_DST:  w_rdata_d = r_dst;
      ADDR_LEN:  w_rdata_d = {{(32-LEN_W){1'b0}}, r_len};
      ADDR_CTRL: w_rdata_d = {30'd0, r_irq_en, 1'b0};
      ADDR_STAT: w_rdata_d = {29'd0, r_err, r_done, w_busy};
      default:   w_rdata_d = 32'd0;
    endcase
  end

  // Next-state and next master-bus values; outputs are registered from these so they change only on edges
  always_comb begin
    w_nxt_state = r_state;
    w_m_req_d   = 1'b0;
    w_m_we_d    = 1'b0;
    w_m_re_d    = 1'b0;
    w_m_addr_d  = r_m_addr;
    w_m_wdata_d = r_m_wdata;
    w_load      = 1'b0;
    w_cap       = 1'b0;
    w_adv       = 1'b0;
    w_set_done  = 1'b0;
    w_set_err   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          if (r_len == {LEN_W{1'b0}}) begin
            w_set_done = 1'b1;
          end else begin
            w_load      = 1'b1;
            w_nxt_state = S_RD;
            w_m_req_d   = 1'b1;
            w_m_re_d    = 1'b1;
            w_m_addr_d  = r_src;
          end
        end else begin
          w_nxt_state = S_IDLE;
        end
      end
      S_RD: begin
        if (i_M_GNT) begin
          w_cap       = 1'b1;
          w_nxt_state = S_RGAP;
        end else if (w_tmo_hit) begin
          w_set_done  = 1'b1;
          w_set_err   = 1'b1;
          w_nxt_state = S_IDLE;
        end else begin
          w_m_req_d = 1'b1;
          w_m_re_d  = 1'b1;
        end
      end
      S_RGAP: begin
        w_nxt_state = S_WR;
        w_m_req_d   = 1'b1;
        w_m_we_d    = 1'b1;
        w_m_addr_d  = r_da;
        w_m_wdata_d = r_buf;
      end
      S_WR: begin
        if (i_M_GNT) begin
          w_adv       = 1'b1;
          w_nxt_state = S_WGAP;
        end else if (w_tmo_hit) begin
          w_set_done  = 1'b1;
          w_set_err   = 1'b1;
          w_nxt_state = S_IDLE;
        end else begin
          w_m_req_d = 1'b1;
          w_m_we_d  = 1'b1;
        end
      end
      S_WGAP: begin
        if (r_cnt == {LEN_W{1'b0}}) begin
          w_set_done  = 1'b1;
          w_nxt_state = S_IDLE;
        end else begin
          w_nxt_state = S_RD;
          w_m_req_d   = 1'b1;
          w_m_re_d    = 1'b1;
          w_m_addr_d  = r_sa;
        end
      end
      default: w_nxt_state = S_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge i_CLK) begin
    if (i_RST) r_state <= S_IDLE;
    else       r_state <= w_nxt_state;
  end

  // Transfer datapath and registered master outputs; working addresses wrap modulo 2^32
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      r_cnt     <= {LEN_W{1'b0}};
      r_sa      <= 32'd0;
      r_da      <= 32'd0;
      r_buf     <= 32'd0;
      r_m_req   <= 1'b0;
      r_m_we    <= 1'b0;
      r_m_re    <= 1'b0;
      r_m_addr  <= 32'd0;
      r_m_wdata <= 32'd0;
    end else begin
      r_m_req   <= w_m_req_d;
      r_m_we    <= w_m_we_d;
      r_m_re    <= w_m_re_d;
      r_m_addr  <= w_m_addr_d;
      r_m_wdata <= w_m_wdata_d;
      if (w_load) begin
        r_cnt <= r_len;
        r_sa  <= r_src;
        r_da  <= r_dst;
      end else if (w_adv) begin
        r_cnt <= r_cnt - LEN_W'(1);
        r_sa  <= r_sa + 32'd4;
        r_da  <= r_da + 32'd4;
      end
      if (w_cap) r_buf <= i_M_RDATA;
    end
  end

  // Programming registers and status; a done/err set wins over a same-cycle clear
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      r_src    <= 32'd0;
      r_dst    <= 32'd0;
      r_len    <= {LEN_W{1'b0}};
      r_irq_en <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      if (w_wr && !w_busy && (i_ADDR == ADDR_SRC)) r_src <= {i_WDATA[31:2], 2'b00};
      if (w_wr && !w_busy && (i_ADDR == ADDR_DST)) r_dst <= {i_WDATA[31:2], 2'b00};
      if (w_wr && !w_busy && (i_ADDR == ADDR_LEN)) r_len <= i_WDATA[LEN_W-1:0];
      if (w_wr && (i_ADDR == ADDR_CTRL))           r_irq_en <= i_WDATA[1];
      if (w_set_done)                                              r_done <= 1'b1;
      else if (w_wr && (i_ADDR == ADDR_STAT) && i_WDATA[1])        r_done <= 1'b0;
      if (w_set_err)                                               r_err <= 1'b1;
      else if (w_wr && (i_ADDR == ADDR_STAT) && i_WDATA[2])        r_err <= 1'b0;
    end
  end

  // Responder grant and read data, one cycle after the request
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      r_gnt   <= 1'b0;
      r_rdata <= 32'd0;
    end else begin
      r_gnt   <= i_REQ & i_CE;
      r_rdata <= w_rd ? w_rdata_d : 32'd0;
    end
  end

  assign o_RDATA   = r_rdata;
  assign o_GNT     = r_gnt;
  assign o_M_REQ   = r_m_req;
  assign o_M_WE    = r_m_we;
  assign o_M_RE    = r_m_re;
  assign o_M_ADDR  = r_m_addr;
  assign o_M_WDATA = r_m_wdata;
  assign o_IRQ     = r_done & r_irq_en;

endmodule

// File: tb/tb_dma_copy.sv
// tb_dma_copy: directed and randomized checks of dma_copy against a simple
// model. Memory is a pure function of the address, and each transfer is a list of expected beats.
`timescale 1ns/1ps
module tb_dma_copy;
  localparam int TMO = 256;

  logic        clk = 1'b0;
  logic        rst, ce, we, re, req;
  logic [31:0] addr, wdata;
  logic [31:0] rdata, m_addr, m_wdata, m_rdata;
  logic        gnt, m_req, m_we, m_re, m_gnt, irq;

  int n_checks = 0, n_fail = 0;
  int n_req_cyc = 0, n_hold = 0;
  int g_delay = 0, wcnt = 0;
  logic gnt_en = 1'b1;
  logic [31:0] q_rd[$], q_wa[$], q_wd[$];
  logic        m_hold_r = 1'b0, m_gap_r = 1'b0, p_we = 1'b0, p_re = 1'b0;
  logic [31:0] p_addr = 32'd0, p_wdata = 32'd0;

  always #5 clk = ~clk;

  dma_copy dut (
    .i_CLK(clk), .i_RST(rst), .i_CE(ce), .i_WE(we), .i_RE(re),
    .i_ADDR(addr), .i_WDATA(wdata), .i_REQ(req),
    .o_RDATA(rdata), .o_GNT(gnt),
    .o_M_REQ(m_req), .o_M_WE(m_we), .o_M_RE(m_re),
    .o_M_ADDR(m_addr), .o_M_WDATA(m_wdata),
    .i_M_RDATA(m_rdata), .i_M_GNT(m_gnt), .o_IRQ(irq)
  );

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Target model: grant after g_delay waiting cycles, memory content derived from the address
  assign m_gnt   = m_req && gnt_en && (wcnt >= g_delay);
  assign m_rdata = mem_f(m_addr);
  always @(posedge clk) wcnt <= (m_req && !m_gnt) ? wcnt + 1 : 0;

  // Bus monitor: logs completed beats, checks hold stability and the one-cycle gap after each grant
  always @(posedge clk) begin
    if (rst) begin
      m_hold_r <= 1'b0;
      m_gap_r  <= 1'b0;
    end else begin
      if (m_req) n_req_cyc <= n_req_cyc + 1;
      if (m_hold_r && m_req) begin
        n_hold <= n_hold + 1;
        chk("hold_addr", m_addr, p_addr);
        chk("hold_wdata", m_wdata, p_wdata);
        chk("hold_strb", {30'd0, m_we, m_re}, {30'd0, p_we, p_re});
      end
      if (m_gap_r) chk("gap_req", {31'd0, m_req}, 32'd0);
      if (m_req && m_gnt) begin
        if (m_re) q_rd.push_back(m_addr);
        else begin
          q_wa.push_back(m_addr);
          q_wd.push_back(m_wdata);
        end
      end
      m_hold_r <= m_req && !m_gnt;
      m_gap_r  <= m_req && m_gnt;
      p_addr   <= m_addr;
      p_wdata  <= m_wdata;
      p_we     <= m_we;
      p_re     <= m_re;
    end
  end

  task automatic reg_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    req = 1'b1; ce = 1'b1; we = 1'b1; re = 1'b0; addr = a; wdata = d;
    @(negedge clk);
    req = 1'b0; ce = 1'b0; we = 1'b0;
  endtask

  task automatic reg_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    req = 1'b1; ce = 1'b1; re = 1'b1; we = 1'b0; addr = a;
    @(negedge clk);
    d = rdata;
    chk("rsp_gnt", {31'd0, gnt}, 32'd1);
    req = 1'b0; ce = 1'b0; re = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    logic [31:0] s;
    s = 32'd0;
    for (int k = 0; k < 150; k++) begin
      reg_read(32'h10, s);
      if (s[1]) break;
    end
    chk({tag, "_done"}, {31'd0, s[1]}, 32'd1);
    chk({tag, "_idle"}, {31'd0, s[0]}, 32'd0);
  endtask

  // Reference: LEN beats, read SRC+4k then write DST+4k with the data read
  task automatic check_xfer(input string tag, input logic [31:0] src, input logic [31:0] dst, input int len);
    chk({tag, "_nrd"}, q_rd.size(), len);
    chk({tag, "_nwr"}, q_wa.size(), len);
    for (int k = 0; k < len; k++) begin
      if (k < q_rd.size()) chk({tag, "_rd_addr"}, q_rd[k], src + 32'(4 * k));
      if (k < q_wa.size()) begin
        chk({tag, "_wr_addr"}, q_wa[k], dst + 32'(4 * k));
        chk({tag, "_wr_data"}, q_wd[k], mem_f(src + 32'(4 * k)));
      end
    end
    q_rd.delete(); q_wa.delete(); q_wd.delete();
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d, r, src, dst;
    int len, h0, rq0, irq_en;
    rst = 1'b1; ce = 1'b0; we = 1'b0; re = 1'b0; req = 1'b0; addr = 32'd0; wdata = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_gnt", {31'd0, gnt}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_mreq", {29'd0, m_req, m_we, m_re}, 32'd0);
    chk("rst_maddr", m_addr, 32'd0);
    chk("rst_mwdata", m_wdata, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    rst = 1'b0;
    reg_read(32'h10, d); chk("rst_stat", d, 32'd0);
    reg_read(32'h14, d); chk("unmapped_rd", d, 32'd0);

    // 1: three-word copy, 1-cycle grant, done exactly 12 cycles after START
    g_delay = 0;
    reg_write(32'h00, 32'h100); reg_write(32'h04, 32'h200); reg_write(32'h08, 32'd3);
    reg_write(32'h0C, 32'h3);
    repeat (11) @(negedge clk);
    chk("t1_irq_early", {31'd0, irq}, 32'd0);
    @(negedge clk);
    chk("t1_irq_at12", {31'd0, irq}, 32'd1);
    reg_read(32'h10, d); chk("t1_stat", d, 32'h2);
    check_xfer("t1", 32'h100, 32'h200, 3);

    // 2: one-word copy with IRQ, then clear done
    reg_write(32'h10, 32'h2);
    chk("t2_irq_cleared", {31'd0, irq}, 32'd0);
    reg_write(32'h08, 32'd1); reg_write(32'h0C, 32'h3);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (irq) break;
    end
    chk("t2_irq", {31'd0, irq}, 32'd1);
    reg_write(32'h10, 32'h2);
    chk("t2_irq_clr", {31'd0, irq}, 32'd0);
    check_xfer("t2", 32'h100, 32'h200, 1);

    // 3: LEN=0 finishes at once without bus traffic
    reg_write(32'h08, 32'd0);
    rq0 = n_req_cyc;
    reg_write(32'h0C, 32'h3);
    chk("t3_irq", {31'd0, irq}, 32'd1);
    repeat (5) @(negedge clk);
    chk("t3_no_req", n_req_cyc, rq0);
    reg_read(32'h10, d); chk("t3_stat", d, 32'h2);
    reg_write(32'h10, 32'h2);

    // 4: slow target, 5 waiting cycles per beat with the request held stable
    g_delay = 5;
    reg_write(32'h00, 32'h1000); reg_write(32'h04, 32'h2000); reg_write(32'h08, 32'd2);
    h0 = n_hold;
    reg_write(32'h0C, 32'h1);
    wait_done("t4");
    chk("t4_hold_cycles", n_hold - h0, 32'd20);
    check_xfer("t4", 32'h1000, 32'h2000, 2);
    reg_write(32'h10, 32'h2);

    // 5: source address wraps, programming writes while busy are ignored
    g_delay = 2;
    reg_write(32'h00, 32'hFFFF_FFFC); reg_write(32'h04, 32'h300); reg_write(32'h08, 32'd2);
    reg_write(32'h0C, 32'h1);
    reg_write(32'h08, 32'h55);
    reg_write(32'h00, 32'h1234);
    wait_done("t5");
    reg_read(32'h08, d); chk("t5_len_kept", d, 32'd2);
    reg_read(32'h00, d); chk("t5_src_kept", d, 32'hFFFF_FFFC);
    check_xfer("t5", 32'hFFFF_FFFC, 32'h300, 2);
    reg_write(32'h10, 32'h2);

    // 6: reset in the middle of a write beat
    g_delay = 3;
    reg_write(32'h08, 32'd4); reg_write(32'h0C, 32'h3);
    d = 32'd0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (m_req && m_we) begin d = 32'd1; break; end
    end
    chk("t6_in_wr", d, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_mreq", {29'd0, m_req, m_we, m_re}, 32'd0);
    chk("t6_maddr", m_addr, 32'd0);
    chk("t6_irq", {31'd0, irq}, 32'd0);
    rst = 1'b0;
    reg_read(32'h00, d); chk("t6_src", d, 32'd0);
    reg_read(32'h04, d); chk("t6_dst", d, 32'd0);
    reg_read(32'h08, d); chk("t6_len", d, 32'd0);
    reg_read(32'h10, d); chk("t6_stat", d, 32'd0);
    q_rd.delete(); q_wa.delete(); q_wd.delete();

    // Target that never grants
    gnt_en = 1'b0;
    reg_write(32'h00, 32'h40); reg_write(32'h04, 32'h80); reg_write(32'h08, 32'd1);
    reg_write(32'h0C, 32'h1);
`ifdef DMA_TIMEOUT_EN
    repeat (TMO + 5) @(negedge clk);
    chk("tmo_req", {31'd0, m_req}, 32'd0);
    reg_read(32'h10, d); chk("tmo_stat", d, 32'h6);
    reg_write(32'h10, 32'h6);
    reg_read(32'h10, d); chk("tmo_clear", d, 32'h0);
`else
    repeat (300) @(negedge clk);
    chk("nogrant_req", {31'd0, m_req}, 32'd1);
    reg_read(32'h10, d); chk("nogrant_stat", d, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
`endif
    gnt_en = 1'b1;
    q_rd.delete(); q_wa.delete(); q_wd.delete();

    // Randomized transfers against the reference beat list
    for (int it = 0; it < 8; it++) begin
      r = $urandom;
      if (it % 3 == 0) r = 32'hFFFF_FFF0 | (r & 32'h0000_000F);
      src = r & 32'hFFFF_FFFC;
      dst = $urandom;
      len = $urandom_range(1, 5);
      g_delay = $urandom_range(0, 3);
      irq_en = $urandom_range(0, 1);
      reg_write(32'h10, 32'h6);
      reg_write(32'h00, r);
      reg_write(32'h04, dst);
      reg_write(32'h08, 32'(len));
      reg_read(32'h00, d); chk("rnd_src_align", d, src);
      reg_write(32'h0C, 32'(irq_en * 2 + 1));
      wait_done("rnd");
      chk("rnd_irq", {31'd0, irq}, 32'(irq_en));
      check_xfer("rnd", src, dst & 32'hFFFF_FFFC, len);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
